// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared types for the SPI-slave-to-RAM bridge: the 2-bit frame command codes
// and the bridge FSM states.
// -----------------------------------------------------------------------------
package spi_ram_pkg;

   localparam int CMD_W = 2;

   typedef enum logic [CMD_W-1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      EXEC,
      TX,
      DONE
   } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// -----------------------------------------------------------------------------
// spi_ram_mem
// Word-wide RAM with one write port and one synchronous read port.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  registered read data (mem[raddr_i] from the previous edge)
// -----------------------------------------------------------------------------
module spi_ram_mem #(
   parameter  int DATA_WIDTH = 8,
   parameter  int MEM_DEPTH  = 256,
   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // NOTE: the array has no reset so it maps onto RAM macros; unwritten
   // locations read back as undefined data.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_bridge.sv
// -----------------------------------------------------------------------------
// spi_ram_bridge
// SPI slave that loads write/read pointers, writes words and reads words back
// from an internal RAM. Frame = cmd[1:0] then payload[DATA_WIDTH-1:0], MSB
// first. Both pointers auto-increment and wrap silently.
// Optional feature: define SPI_RAM_BURST_EN to accept back-to-back frames
// within a single SS_n assertion; otherwise the FSM parks in DONE after each
// frame until SS_n is released.
// Ports:
//   clk    in   system clock; MOSI/SS_n sampled on the rising edge
//   rst    in   asynchronous active-high reset
//   MOSI   in   serial data in, MSB first
//   SS_n   in   slave select, active low
//   MISO   out  registered serial read data, MSB first, 0 outside TX
//   busy   out  high whenever the FSM is not IDLE
//   abort  out  one-cycle pulse when SS_n cuts a frame short
// -----------------------------------------------------------------------------
module spi_ram_bridge
   import spi_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic MOSI,
   input  logic SS_n,
   output logic MISO,
   output logic busy,
   output logic abort
);

   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
   localparam int FRAME_W    = DATA_WIDTH + CMD_W;
   localparam int CNT_W      = $clog2(FRAME_W + 1);

   state_e                state_q,  state_d;
   logic [FRAME_W-1:0]    rx_sr_q,  rx_sr_d;
   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] tx_sr_q,  tx_sr_d;
   logic                  miso_q,   miso_d;
   logic                  abort_q,  abort_d;

   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] tx_shift;
   cmd_e                  cmd;
   logic [DATA_WIDTH-1:0] payload;

   assign cmd      = cmd_e'(rx_sr_q[FRAME_W-1 -: CMD_W]);
   assign payload  = rx_sr_q[DATA_WIDTH-1:0];
   assign tx_shift = tx_sr_q << 1;

   // The read port always tracks rd_ptr, so by EXEC the word at rd_ptr is
   // already sitting on mem_rdata. Read data only feeds tx_sr/MISO, never
   // the FSM, so undefined RAM contents cannot corrupt control flow.
   spi_ram_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (payload),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rdata)
   );

   // NOTE: every signal gets its default before the case statement, so no
   // path through this block can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      rx_sr_d  = rx_sr_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      tx_sr_d  = tx_sr_q;
      miso_d   = 1'b0;
      abort_d  = 1'b0;
      mem_we   = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!SS_n) state_d = RX;
         end

         RX: begin
            if (SS_n) begin
`ifdef SPI_RAM_BURST_EN
               // Releasing SS_n between burst frames is a clean end.
               if (cnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = IDLE;
                  abort_d = 1'b1;
               end
`else
               state_d = IDLE;
               abort_d = 1'b1;
`endif
               cnt_d = '0;
            end else begin
               rx_sr_d = {rx_sr_q[FRAME_W-2:0], MOSI};
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                  state_d = EXEC;
                  cnt_d   = '0;
               end
            end
         end

         EXEC: begin
            // The command's action completes even if SS_n rises here.
            case (cmd)
               CMD_WR_ADDR: wr_ptr_d = payload[ADDR_WIDTH-1:0];
               CMD_WR_DATA: begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
               end
               CMD_RD_ADDR: rd_ptr_d = payload[ADDR_WIDTH-1:0];
               CMD_RD_DATA: begin
                  tx_sr_d  = mem_rdata;
                  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
               end
               default: ;
            endcase
            cnt_d = '0;
            if (SS_n) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else if (cmd == CMD_RD_DATA) begin
               state_d = TX;
               miso_d  = mem_rdata[DATA_WIDTH-1];
            end else begin
`ifdef SPI_RAM_BURST_EN
               state_d = RX;
`else
               state_d = DONE;
`endif
            end
         end

         TX: begin
            if (SS_n) begin
               state_d = IDLE;
               abort_d = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef SPI_RAM_BURST_EN
               state_d = RX;
`else
               state_d = DONE;
`endif
               cnt_d = '0;
            end else begin
               tx_sr_d = tx_shift;
               miso_d  = tx_shift[DATA_WIDTH-1];
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            if (SS_n) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rx_sr_q  <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         tx_sr_q  <= '0;
         miso_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rx_sr_q  <= rx_sr_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         tx_sr_q  <= tx_sr_d;
         miso_q   <= miso_d;
         abort_q  <= abort_d;
      end
   end

   assign MISO  = miso_q;
   assign busy  = (state_q != IDLE);
   assign abort = abort_q;

endmodule
